// File: rtl/paws_clken_manager.sv
// Clock-enable and domain-reset manager for a single PLL output clock: PLL lock supervision plus per-channel programmable enable strobes.
// Optional feature macro: PAWS_CLKEN_RESYNC_EN adds the resync input that realigns all channel counters while running.
module paws_clken_manager #(
  parameter int CHANNELS    = 4,
  parameter int DIVW        = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DIV_RESET   = 1,
  localparam int SELW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic                cfg_we,
  input  logic [SELW-1:0]     cfg_sel,
  input  logic [DIVW-1:0]     cfg_div,
  input  logic [DIVW-1:0]     cfg_phase,
`ifdef PAWS_CLKEN_RESYNC_EN
  input  logic                resync,
`endif
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] domain_reset,
  output logic                ready
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOCK, STABLE, RUN} state_t;

  state_t           stateReg, stateNext;
  logic [LCW-1:0]   lockCntReg, lockCntNext;
  logic             lockMeta, lockSync;
  logic             readyReg;
  logic             runHold, runNext, entering, resyncHit, loadAll, countEn;
  logic [DIVW-1:0]  phaseClamp;

  // PLL lock is asynchronous to clkin; two flops before anything looks at it.
  always_ff @(posedge clkin) begin
    if (reset) begin
      lockMeta   <= 1'b0;
      lockSync   <= 1'b0;
      stateReg   <= IDLE;
      lockCntReg <= '0;
      readyReg   <= 1'b0;
    end else begin
      lockMeta   <= pll_locked;
      lockSync   <= lockMeta;
      stateReg   <= stateNext;
      lockCntReg <= lockCntNext;
      readyReg   <= runHold;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    lockCntNext = lockCntReg;
    case (stateReg)
      IDLE:      stateNext = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lockSync) begin
          stateNext   = STABLE;
          lockCntNext = '0;
        end
      end
      STABLE: begin
        if (!lockSync)                    stateNext = WAIT_LOCK;
        else if (lockCntReg == LOCK_LAST) stateNext = RUN;
        else                              lockCntNext = lockCntReg + LCW'(1);
      end
      RUN:       if (!lockSync) stateNext = WAIT_LOCK;
      default:   stateNext = IDLE;
    endcase
  end

  assign runNext  = (stateNext == RUN);
  assign runHold  = (stateReg == RUN) && runNext;
  assign entering = (stateReg == STABLE) && runNext;

`ifdef PAWS_CLKEN_RESYNC_EN
  assign resyncHit = runHold && resync;
`else
  assign resyncHit = 1'b0;
`endif

  assign loadAll    = entering || resyncHit;
  assign countEn    = runHold && !resyncHit;
  assign phaseClamp = (cfg_phase > cfg_div) ? cfg_div : cfg_phase;
  assign ready      = readyReg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gChan
    logic [DIVW-1:0] cntReg, cntNext, divReg, divNext, phaseReg, phaseNext;
    logic [DIVW-1:0] shDivReg, shPhaseReg;
    logic            pendReg, pendNext, ceReg, ceNext, drstReg, drstNext;
    logic            hit, wrap, apply;

    // Out-of-range selects match no channel, so those writes simply vanish.
    assign hit   = cfg_we && (cfg_sel == SELW'(gi));
    assign wrap  = countEn && (cntReg == divReg);
    assign apply = pendReg && (loadAll || wrap);

    always_comb begin
      divNext   = divReg;
      phaseNext = phaseReg;
      cntNext   = cntReg;
      pendNext  = pendReg;
      if (apply) begin
        divNext   = shDivReg;
        phaseNext = shPhaseReg;
        pendNext  = 1'b0;
      end
      if (loadAll)      cntNext = phaseNext;
      else if (wrap)    cntNext = apply ? phaseNext : '0;
      else if (countEn) cntNext = cntReg + DIVW'(1);
      // A write landing on the consuming edge stays queued for the next one.
      if (hit) pendNext = 1'b1;
      ceNext   = runNext && !resyncHit && (cntNext == divNext);
      drstNext = !runNext || (drstReg && !ceNext);
    end

    always_ff @(posedge clkin) begin
      if (reset) begin
        cntReg     <= '0;
        divReg     <= DIVW'(DIV_RESET);
        phaseReg   <= '0;
        shDivReg   <= DIVW'(DIV_RESET);
        shPhaseReg <= '0;
        pendReg    <= 1'b0;
        ceReg      <= 1'b0;
        drstReg    <= 1'b1;
      end else begin
        cntReg   <= cntNext;
        divReg   <= divNext;
        phaseReg <= phaseNext;
        pendReg  <= pendNext;
        ceReg    <= ceNext;
        drstReg  <= drstNext;
        if (hit) begin
          shDivReg   <= cfg_div;
          shPhaseReg <= phaseClamp;
        end
      end
    end

    assign ce[gi]           = ceReg;
    assign domain_reset[gi] = drstReg;
  end

endmodule

// File: tb/tb_paws_clken_manager.sv
// Directed bench for paws_clken_manager: lock sequencing, enable periods, live reconfiguration and lock loss.
// Exercises resync only when PAWS_CLKEN_RESYNC_EN is defined.
module tb_paws_clken_manager;
  localparam int CHANNELS = 4;
  localparam int DIVW     = 8;
  localparam int SELW     = 2;

  logic                clkin = 1'b0;
  logic                reset;
  logic                pll_locked;
  logic                cfg_we;
  logic [SELW-1:0]     cfg_sel;
  logic [DIVW-1:0]     cfg_div;
  logic [DIVW-1:0]     cfg_phase;
`ifdef PAWS_CLKEN_RESYNC_EN
  logic                resync;
`endif
  logic [CHANNELS-1:0] ce;
  logic [CHANNELS-1:0] domain_reset;
  logic                ready;

  int nPass  = 0;
  int nFail  = 0;
  int nTotal = 0;

  paws_clken_manager #(
    .CHANNELS(4), .DIVW(8), .LOCK_CYCLES(16), .DIV_RESET(1)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_locked(pll_locked),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
`ifdef PAWS_CLKEN_RESYNC_EN
    .resync(resync),
`endif
    .ce(ce), .domain_reset(domain_reset), .ready(ready)
  );

  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nTotal++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cfgWrite(input int sel, input int div, input int phase);
    cfg_we    = 1'b1;
    cfg_sel   = SELW'(sel);
    cfg_div   = DIVW'(div);
    cfg_phase = DIVW'(phase);
  endtask

  logic [3:0] ceLive[10]  = '{4'h0, 4'hB, 4'h0, 4'hB, 4'h4, 4'hB, 4'h0, 4'hB, 4'h0, 4'hF};
  logic [3:0] ceRelock[9] = '{4'hB, 4'h0, 4'h9, 4'h4, 4'hB, 4'h0, 4'h9, 4'h0, 4'hF};
  logic [3:0] drRelock[9] = '{4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] ceEdge[7]   = '{4'h9, 4'h7, 4'h1, 4'hF, 4'h1, 4'h7, 4'h9};

  initial begin
    int hit1;
    int hit2;
    reset = 1'b1; pll_locked = 1'b1; cfg_we = 1'b0;
    cfg_sel = '0; cfg_div = '0; cfg_phase = '0;
`ifdef PAWS_CLKEN_RESYNC_EN
    resync = 1'b0;
`endif
    repeat (3) tick();
    check("rst_ce", 32'(ce), 32'h0);
    check("rst_drst", 32'(domain_reset), 32'hF);
    check("rst_ready", 32'(ready), 32'h0);
    reset = 1'b0;

    // Power-up with lock held: RUN entry at edge 19, ready visible after edge 20.
    repeat (19) tick();
    check("up_ready_e19", 32'(ready), 32'h0);
    check("up_ce_e19", 32'(ce), 32'h0);
    check("up_drst_e19", 32'(domain_reset), 32'hF);
    tick();
    check("up_ready_e20", 32'(ready), 32'h1);
    check("up_ce_e20", 32'(ce), 32'hF);
    check("up_drst_e20", 32'(domain_reset), 32'h0);
    tick(); check("up_ce_e21", 32'(ce), 32'h0);
    tick(); check("up_ce_e22", 32'(ce), 32'hF);
    tick(); check("up_ce_e23", 32'(ce), 32'h0);

    // Mid-period write to ch2: old period holds until its wrap.
    cfgWrite(2, 4, 0);
    tick(); check("live_ce_e24", 32'(ce), 32'hF);
    cfg_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("live_ce_%0d", i), 32'(ce), 32'(ceLive[i]));
    end

    // Lock loss while running.
    pll_locked = 1'b0;
    tick(); check("loss_ce_1", 32'(ce), 32'h0);
    tick(); check("loss_ce_2", 32'(ce), 32'hB);
    check("loss_ready_2", 32'(ready), 32'h1);
    tick();
    check("loss_ce_3", 32'(ce), 32'h0);
    check("loss_drst_3", 32'(domain_reset), 32'hF);
    check("loss_ready_3", 32'(ready), 32'h0);

    // Relock with a pending ch1 div=3 phase=2 written while not running.
    pll_locked = 1'b1;
    cfgWrite(1, 3, 2);
    tick();
    cfg_we = 1'b0;
    repeat (17) tick();
    check("relock_ready_r18", 32'(ready), 32'h0);
    tick();
    check("relock_ce_r19", 32'(ce), 32'h0);
    check("relock_drst_r19", 32'(domain_reset), 32'hF);
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("relock_ce_%0d", i), 32'(ce), 32'(ceRelock[i]));
      check($sformatf("relock_drst_%0d", i), 32'(domain_reset), 32'(drRelock[i]));
      if (i == 0) check("relock_ready_r20", 32'(ready), 32'h1);
    end

    // Reset mid-operation, then a one-cycle lock glitch during STABLE.
    reset = 1'b1;
    tick();
    check("rst2_ce", 32'(ce), 32'h0);
    check("rst2_drst", 32'(domain_reset), 32'hF);
    check("rst2_ready", 32'(ready), 32'h0);
    reset = 1'b0;
    repeat (13) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (6) tick();
    check("glitch_ready_g20", 32'(ready), 32'h0);
    repeat (13) tick();
    check("glitch_ready_g33", 32'(ready), 32'h0);
    tick();
    check("glitch_ready_g34", 32'(ready), 32'h1);
    check("glitch_ce_g34", 32'(ce), 32'hF);

    // ch0 div=0 written on its wrap cycle; ch3 phase clamped to div=2.
    cfgWrite(0, 0, 0);
    tick(); check("edge_ce_g35", 32'(ce), 32'h0);
    cfgWrite(3, 2, 9);
    tick(); check("edge_ce_g36", 32'(ce), 32'hF);
    cfg_we = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("edge_ce_%0d", i), 32'(ce), 32'(ceEdge[i]));
    end

    // Maximum divider on ch1: period 256, first strobe 256 edges after the write.
    cfgWrite(1, 255, 0);
    tick();
    cfg_we = 1'b0;
    hit1 = -1;
    hit2 = -1;
    for (int k = 1; k <= 600; k++) begin
      tick();
      if (ce[1]) begin
        if (hit1 < 0) hit1 = k;
        else if (hit2 < 0) hit2 = k;
      end
    end
    check("maxdiv_first", 32'(hit1), 32'd256);
    check("maxdiv_second", 32'(hit2), 32'd512);

`ifdef PAWS_CLKEN_RESYNC_EN
    cfgWrite(0, 2, 0);
    tick();
    cfgWrite(1, 5, 0);
    tick();
    cfg_we = 1'b0;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    check("resync_ce_0", 32'(ce[1:0]), 32'h0);
    for (int k = 1; k < 12; k++) begin
      tick();
      check($sformatf("resync_ce_%0d", k), 32'(ce[1:0]),
            32'({(k % 6) == 5, (k % 3) == 2}));
    end
`endif

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
